// File: rtl/twos_compliment_arbiter.sv
// rtl/twos_compliment_arbiter.sv - round-robin arbiter sharing one twos_compliment unit
// Sequences the unit's en/ready handshake with a timeout and returns results with a one-cycle ack.
module twos_compliment_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]     ack,
   output logic [7:0]          result,
   output logic                err,
   output logic                busy,
   output logic                tc_en,
   output logic [7:0]          tc_a,
   input  logic                tc_ready,
   input  logic [7:0]          tc_output
);

   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [PW-1:0]     r_rr_ptr;
   logic [PW-1:0]     r_grant;
   logic [TW-1:0]     r_timer;
   logic [7:0]        r_tc_a;
   logic [7:0]        r_result;
   logic [NREQ-1:0]   r_ack;
   logic              r_err;

   logic [PW-1:0]     w_grant;
   logic [PW-1:0]     w_idx;
   logic              w_found;
   logic [7:0]        w_sel_data;
   logic              w_timeout;
   logic [PW-1:0]     w_ptr_next;

   // Scan from the farthest offset down so the nearest set bit after rr_ptr wins.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_idx = PW'((int'(r_rr_ptr) + i) % NREQ);
         if (req[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_sel_data = req_data[int'(w_grant)*8 +: 8];
   assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
   assign w_ptr_next = (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_found) w_next = S_BUSY;
         S_BUSY:    if (tc_ready || w_timeout) w_next = S_RELEASE;
         S_RELEASE: if (!tc_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // ack/err are pulses: cleared every cycle unless BUSY is being left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_timer  <= '0;
         r_tc_a   <= '0;
         r_result <= '0;
         r_ack    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_grant;
                  r_tc_a  <= w_sel_data;
                  r_timer <= '0;
               end
            end
            S_BUSY: begin
               r_timer <= r_timer + 1'b1;
               if (tc_ready) begin
                  r_result       <= tc_output;
                  r_ack[r_grant] <= 1'b1;
                  r_rr_ptr       <= w_ptr_next;
               end else if (w_timeout) begin
                  r_result       <= 8'h00;
                  r_err          <= 1'b1;
                  r_ack[r_grant] <= 1'b1;
                  r_rr_ptr       <= w_ptr_next;
               end
            end
            default: ;
         endcase
      end
   end

   // tc_en decodes straight from state so an async reset drops it at once.
   assign tc_en  = (r_state == S_BUSY);
   assign busy   = (r_state != S_IDLE);
   assign tc_a   = r_tc_a;
   assign result = r_result;
   assign ack    = r_ack;
   assign err    = r_err;

endmodule
